// File: rtl/montgomery_exp_ctrl.sv
// Modular exponentiation front/back end: derives N', R mod N and R^2 mod N, maps the base into
// the Montgomery domain, runs the external exponentiator and maps its result back.
module montgomery_exp_ctrl #(
    parameter int unsigned BITS     = 512,
    parameter int unsigned LOG_BITS = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] base,
    input  logic [BITS-1:0] exponent,
    input  logic [BITS-1:0] N,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [BITS-1:0] result,
    output logic            exp_start,
    output logic [BITS-1:0] exp_base_mont,
    output logic [BITS-1:0] exp_exponent,
    output logic [BITS-1:0] exp_N,
    output logic [BITS-1:0] exp_N_prime,
    output logic [BITS-1:0] exp_one_mont,
    input  logic            exp_finish,
    input  logic [BITS-1:0] exp_result
);
    localparam int unsigned     CW       = LOG_BITS + 1;
    localparam logic [CW-1:0]   CntHalf  = CW'(BITS - 1);
    localparam logic [CW-1:0]   CntLast  = CW'(2 * BITS - 1);
    localparam logic [BITS-1:0] OneB     = BITS'(1);

    typedef enum logic [2:0] {
        StIdle, StNprime, StRmod, StTomont, StExpgo, StExpwait, StFrommont, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] base_q, base_d, exponent_q, exponent_d, n_q, n_d;
    logic [BITS-1:0] y_q, y_d, p_q, p_d, n_prime_q, n_prime_d, one_mont_q, one_mont_d;
    logic [BITS-1:0] base_mont_q, base_mont_d, res_mont_q, res_mont_d, result_q, result_d;
    logic [BITS:0]   r_q, r_d, r_dbl, r_red;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d, exp_start_q, exp_start_d;

    logic [LOG_BITS-1:0] idx;
    logic [BITS-1:0]     y_nxt, p_nxt, mm_a, mm_b, mm_p;
    logic [BITS+1:0]     mm_t;

    assign idx   = cnt_q[LOG_BITS-1:0];
    assign r_dbl = r_q << 1;
    assign r_red = (r_dbl >= {1'b0, n_q}) ? r_dbl - {1'b0, n_q} : r_dbl;

    // Operands are zero outside the two conversion states to keep the multiplier quiet.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            StTomont:   begin mm_a = base_q;     mm_b = r_q[BITS-1:0]; end
            StFrommont: begin mm_a = res_mont_q; mm_b = OneB;          end
            default:    ;
        endcase
    end

    // Bit-serial Montgomery product A*B*R^-1 mod N, unrolled; t stays below 4N.
    always_comb begin
        mm_t = '0;
        for (int k = 0; k < BITS; k++) begin
            if (mm_a[k]) mm_t = mm_t + {2'b00, mm_b};
            if (mm_t[0]) mm_t = mm_t + {2'b00, n_q};
            mm_t = mm_t >> 1;
        end
        if (mm_t >= {2'b00, n_q}) mm_t = mm_t - {2'b00, n_q};
        mm_p = mm_t[BITS-1:0];
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        exponent_d  = exponent_q;
        n_d         = n_q;
        y_d         = y_q;
        p_d         = p_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        n_prime_d   = n_prime_q;
        one_mont_d  = one_mont_q;
        base_mont_d = base_mont_q;
        res_mont_d  = res_mont_q;
        result_d    = result_q;
        err_d       = err_q;
        exp_start_d = 1'b0;
        y_nxt       = y_q;
        p_nxt       = p_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d     = base;
                    exponent_d = exponent;
                    n_d        = N;
                    if (!N[0]) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = StDone;
                    end else begin
                        err_d   = 1'b0;
                        y_d     = OneB;
                        p_d     = N;
                        cnt_d   = CW'(1);
                        state_d = StNprime;
                    end
                end
            end
            StNprime: begin
                // Invariant p == N*y mod 2^BITS with p == 1 mod 2^i.
                if (p_q[idx]) begin
                    y_nxt = y_q | (OneB << idx);
                    p_nxt = p_q + (n_q << idx);
                end
                y_d   = y_nxt;
                p_d   = p_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntHalf) begin
                    n_prime_d = ~y_nxt + OneB;
                    r_d       = {1'b0, OneB};
                    cnt_d     = '0;
                    state_d   = StRmod;
                end
            end
            StRmod: begin
                r_d   = r_red;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntHalf) one_mont_d = r_red[BITS-1:0];
                if (cnt_q == CntLast) state_d = StTomont;
            end
            StTomont: begin
                base_mont_d = mm_p;
                exp_start_d = 1'b1;
                state_d     = StExpgo;
            end
            StExpgo: state_d = StExpwait;
            StExpwait: begin
                if (exp_finish) begin
                    res_mont_d = exp_result;
                    state_d    = StFrommont;
                end
            end
            StFrommont: begin
                result_d = mm_p;
                state_d  = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            exponent_q  <= '0;
            n_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            n_prime_q   <= '0;
            one_mont_q  <= '0;
            base_mont_q <= '0;
            res_mont_q  <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            exp_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            exponent_q  <= exponent_d;
            n_q         <= n_d;
            y_q         <= y_d;
            p_q         <= p_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            n_prime_q   <= n_prime_d;
            one_mont_q  <= one_mont_d;
            base_mont_q <= base_mont_d;
            res_mont_q  <= res_mont_d;
            result_q    <= result_d;
            err_q       <= err_d;
            exp_start_q <= exp_start_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign err           = err_q;
    assign result        = result_q;
    assign exp_start     = exp_start_q;
    assign exp_base_mont = base_mont_q;
    assign exp_exponent  = exponent_q;
    assign exp_N         = n_q;
    assign exp_N_prime   = n_prime_q;
    assign exp_one_mont  = one_mont_q;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl at BITS=8 with a behavioural exponentiator and plain-arithmetic
// reference for N', R mod N, base*R mod N and base^e mod N.
module tb_montgomery_exp_ctrl;
    localparam int unsigned BITS     = 8;
    localparam int unsigned LOG_BITS = 3;

    logic            clk = 1'b0;
    logic            rst_n, start;
    logic [BITS-1:0] base, exponent, n_in;
    logic            busy, done, err, exp_start;
    logic [BITS-1:0] result, exp_base_mont, exp_exponent, exp_N, exp_N_prime, exp_one_mont;
    logic            exp_finish = 1'b0;
    logic [BITS-1:0] exp_result = '0;

    int checks = 0;
    int errors = 0;

    montgomery_exp_ctrl #(.BITS(BITS), .LOG_BITS(LOG_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent), .N(n_in),
        .busy(busy), .done(done), .err(err), .result(result), .exp_start(exp_start),
        .exp_base_mont(exp_base_mont), .exp_exponent(exp_exponent), .exp_N(exp_N),
        .exp_N_prime(exp_N_prime), .exp_one_mont(exp_one_mont), .exp_finish(exp_finish),
        .exp_result(exp_result)
    );

    always #5 clk = ~clk;

    function automatic longint modpow(longint b, longint e, longint n);
        longint r = 1 % n;
        for (longint i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    function automatic longint inv_mod(longint a, longint n);
        for (longint k = 1; k < n; k++) if (((a * k) % n) == 1) return k;
        return 0;
    endfunction

    function automatic longint nprime_ref(longint n);
        for (longint y = 1; y < 256; y++) if (((n * y) % 256) == 1) return (256 - y) % 256;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Behavioural exponentiator: Montgomery-domain square-and-multiply result after a random wait.
    int unsigned     extra_delay = 0;
    int              hold_bad_cnt = 0;
    bit              em_pend = 1'b0;
    int unsigned     em_cnt;
    longint          em_res;
    logic [BITS-1:0] em_bm, em_n, em_e, em_np, em_om;

    always @(negedge clk) begin
        if (!rst_n) begin
            em_pend    = 1'b0;
            exp_finish = 1'b0;
        end else begin
            exp_finish = 1'b0;
            exp_result = BITS'($urandom);
            if (em_pend) begin
                if (exp_base_mont !== em_bm || exp_N !== em_n || exp_exponent !== em_e ||
                    exp_N_prime !== em_np || exp_one_mont !== em_om) hold_bad_cnt++;
                if (em_cnt == 0) begin
                    exp_finish = 1'b1;
                    exp_result = BITS'(em_res);
                    em_pend    = 1'b0;
                end else em_cnt--;
            end
            if (exp_start === 1'b1) begin
                longint rinv, acc;
                em_pend = 1'b1;
                em_cnt  = $urandom_range(0, 6) + extra_delay;
                em_bm = exp_base_mont; em_n = exp_N; em_e = exp_exponent;
                em_np = exp_N_prime;   em_om = exp_one_mont;
                rinv = inv_mod(256, longint'(em_n));
                acc  = 256 % longint'(em_n);
                for (int i = 0; i < int'(em_e); i++)
                    acc = (((acc * em_bm) % em_n) * rinv) % em_n;
                em_res = acc;
            end
        end
    end

    task automatic run(input logic [BITS-1:0] b, input logic [BITS-1:0] e,
                       input logic [BITS-1:0] n, input bit poke, input string tag);
        int start_n = 0, fin_n = 0, done_n = 0, pulses = 0, hold0;
        logic [BITS-1:0] np_s = '0, om_s = '0, bm_s = '0, res_s = '0;
        logic            err_s = 1'b0;
        hold0 = hold_bad_cnt;
        @(negedge clk);
        base = b; exponent = e; n_in = n; start = 1'b1;
        for (int c = 1; c <= 400 && done_n == 0; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) check({tag, "/busy"}, busy, 1'b1);
            if (exp_start === 1'b1) begin
                pulses++;
                if (start_n == 0) begin
                    start_n = c; np_s = exp_N_prime; om_s = exp_one_mont; bm_s = exp_base_mont;
                end
            end
            if (exp_finish === 1'b1 && start_n != 0 && c > start_n && fin_n == 0) fin_n = c;
            if (done === 1'b1) begin
                done_n = c; res_s = result; err_s = err;
            end
            start = poke && (c == 12 || (start_n != 0 && c == start_n + 1));
        end
        start = 1'b0;
        check({tag, "/done_seen"}, (done_n != 0), 1'b1);
        if (n[0]) begin
            check({tag, "/exp_start_cycle"}, start_n, 3 * BITS + 1);
            check({tag, "/exp_start_count"}, pulses, 1);
            check({tag, "/finish_seen"}, (fin_n != 0), 1'b1);
            check({tag, "/done_latency"}, done_n, fin_n + 2);
            check({tag, "/n_prime"}, np_s, nprime_ref(n));
            check({tag, "/one_mont"}, om_s, 256 % longint'(n));
            check({tag, "/base_mont"}, bm_s, (longint'(b) * 256) % longint'(n));
            check({tag, "/operand_hold"}, hold_bad_cnt - hold0, 0);
            check({tag, "/result"}, res_s, modpow(b, e, n));
            check({tag, "/err"}, err_s, 1'b0);
        end else begin
            check({tag, "/err_done_cycle"}, done_n, 1);
            check({tag, "/err"}, err_s, 1'b1);
            check({tag, "/err_result"}, res_s, 0);
            check({tag, "/exp_start_count"}, pulses, 0);
        end
        @(negedge clk);
        #1;
        check({tag, "/done_single"}, done, 1'b0);
        check({tag, "/idle_after"}, busy, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/busy"}, busy, 1'b0);
        check({tag, "/done"}, done, 1'b0);
        check({tag, "/err"}, err, 1'b0);
        check({tag, "/exp_start"}, exp_start, 1'b0);
        check({tag, "/result"}, result, 0);
        check({tag, "/exp_N"}, exp_N, 0);
        check({tag, "/exp_N_prime"}, exp_N_prime, 0);
        check({tag, "/exp_base_mont"}, exp_base_mont, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; base = '0; exponent = '0; n_in = '0;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        run(8'd5, 8'd3, 8'd187, 1'b0, "basic");
        run(8'd2, 8'd250, 8'd251, 1'b0, "fermat");
        run(8'd7, 8'd0, 8'd187, 1'b1, "exp0_poke");
        run(8'd0, 8'd5, 8'd187, 1'b0, "base0");
        run(8'd9, 8'd9, 8'd186, 1'b0, "even_n");
        run(8'd5, 8'd3, 8'd187, 1'b1, "after_even");
        for (int t = 0; t < 6; t++) begin
            logic [BITS-1:0] rn, rb, re;
            rn = BITS'($urandom_range(1, 127) * 2 + 1);
            rb = BITS'($urandom_range(0, int'(rn) - 1));
            re = BITS'($urandom_range(0, 255));
            run(rb, re, rn, bit'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        // Reset while lifting N'.
        @(negedge clk);
        base = 8'd5; exponent = 8'd3; n_in = 8'd187; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_cleared("rst_nprime");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset while the exponentiator is running.
        run(8'd7, 8'd2, 8'd187, 1'b0, "pre_ew");
        extra_delay = 20;
        @(negedge clk);
        base = 8'd5; exponent = 8'd3; n_in = 8'd187; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (exp_start === 1'b1) seen = 1'b1;
        end
        check("rst_expwait/reached", seen, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_cleared("rst_expwait");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra_delay = 0;
        run(8'd5, 8'd3, 8'd187, 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/montgomery_exp_ctrl.md
# montgomery_exp_ctrl

Front/back-end controller for modular exponentiation, result = base^exponent mod N. It accepts plain-domain operands and computes N_prime = -N^-1 mod 2^BITS, one_mont = R mod N and R2 = R^2 mod N, with R = 2^BITS. It converts base into the Montgomery domain and drives the square-and-multiply exponentiator over its start/finish handshake as initiator. It then converts the exponentiator's result back to the plain domain. It owns one combinational montgomery_mult instance (P = A·B·R^-1 mod N, fully reduced for A, B < N).

## Interface
- BITS, 512, operand width; must match the exponentiator.
- LOG_BITS, 9, log2(BITS).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- base  in  BITS  plain base; requirement: base < N.
- exponent  in  BITS  exponent.
- N  in  BITS  modulus; must be odd.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and err are valid in that cycle.
- err  out  1  high with done when N is even.
- result  out  BITS  plain-domain result; held until the next accepted start.
- exp_start  out  1  one-cycle start pulse to the exponentiator.
- exp_base_mont, exp_exponent, exp_N, exp_N_prime, exp_one_mont  out  BITS each  exponentiator operands; registered, stable from exp_start until exp_finish.
- exp_finish  in  1  exponentiator completion strobe (high for one cycle).
- exp_result  in  BITS  exponentiator result; valid only while exp_finish is high.

## Operation
- States: IDLE, NPRIME, RMOD, TOMONT, EXPGO, EXPWAIT, FROMMONT, DONE.
- IDLE, start=1:
  - Capture base, exponent and N into registers.
  - If N[0]=0: set err=1, set result=0, go to DONE. No exponentiator activity.
  - Otherwise: clear err, set y=1, p=N, i=1, go to NPRIME.
- NPRIME: Hensel lift of the inverse, one bit per cycle, i = 1..BITS-1.
  - If p[i]=1: y += 2^i and p += N<<i, both mod 2^BITS.
  - After i = BITS-1: exp_N_prime = (~y)+1 mod 2^BITS; set r=1, j=0; go to RMOD.
- RMOD: one modular doubling per cycle, 2·BITS cycles.
  - r is BITS+1 bits wide; r = 2r, then r -= N if 2r >= N.
  - After doubling BITS: latch r[BITS-1:0] into exp_one_mont.
  - After doubling 2·BITS: r holds R2; go to TOMONT.
- TOMONT: exp_base_mont = mont_mult(base_reg, R2); go to EXPGO.
- EXPGO: exp_start=1 for exactly this cycle; go to EXPWAIT.
- EXPWAIT:
  - Hold all exp_* operands.
  - On exp_finish=1: capture exp_result into res_mont; go to FROMMONT.
  - No timeout.
- FROMMONT: result = mont_mult(res_mont, 1); go to DONE.
- DONE: done=1; go to IDLE.
- Multiplier operand mux: A/B = (base_reg, R2) in TOMONT, (res_mont, 1) in FROMMONT, and 0 elsewhere to limit toggling.
- start outside IDLE is ignored, and DONE never accepts start. A start asserted in the DONE cycle must be held to be taken in IDLE.
- exp_finish outside EXPWAIT is ignored.
- Reset (asynchronous, any state, including mid-NPRIME or EXPWAIT):
  - state=IDLE; busy=0, done=0, err=0, exp_start=0.
  - result=0; all exp_* operand registers and internal registers = 0.
  - The exponentiator must be reset in the same domain; this block does not re-synchronise with an exponentiator that is still running.

## Timing
- Start accepted at edge k.
- NPRIME covers cycles k+1 .. k+BITS-1.
- RMOD covers k+BITS .. k+3·BITS-1.
- TOMONT at k+3·BITS.
- exp_start high in cycle k+3·BITS+1.
- exp_finish seen at cycle f, FROMMONT at f+1, done at f+2.
- Total latency = 3·BITS + 3 + (f - (k+3·BITS+1)) cycles.
- Even-N error path: done (with err=1) in cycle k+1.
- All outputs are registered except busy and done, which decode state.

## Test plan
- BITS=8, N=187, base=5, exponent=3 -> internal checks exp_N_prime=141, exp_one_mont=69, R2=86; done with result=125, err=0. Bench uses a behavioral exponentiator model.
- BITS=8, N=251, base=2, exponent=250 (Fermat) -> result=1. Also check exp_start is high exactly once, 25 cycles after the accepting edge.
- BITS=8, N=187, base=7, exponent=0 -> result=1. base=0, exponent=5 -> result=0.
- BITS=8, N=186 (even) -> done and err=1 in cycle k+1, result=0, exp_start never asserted.
- start pulsed during RMOD and during EXPWAIT -> ignored; results are unchanged; exactly one done per accepted start.
- rst_n low mid-NPRIME, and again in EXPWAIT -> outputs cleared immediately (asynchronously). A fresh run after reset (N=187, base=5, exponent=3) gives 125.
